ftdi_sync_burst: RTL and testbench
==================================

// Module: ftdi_sync_burst
// PURPOSE
// - Parametrised FT245-style synchronous FIFO bridge.
// - Successor to the 8-bit FTDI sync bridge: configurable bus width and FIFO depths,
//   fair TX/RX arbitration with a burst limit, and a programmable OE->RD turnaround.
// - Adds a SIWU send-immediate flush, raised after TX goes idle or on request.
// - Sits between the FTDI pins (IOB-registered) and the internal valid/accept byte streams.
// PARAMETERS
// - DATA_W     8   FTDI data bus and stream width; tested at 8 and 16.
// - TX_DEPTH   64  TX FIFO entries. Power of two, >= 4.
// - RX_DEPTH   64  RX FIFO entries. Power of two, >= 4.
// - BURST_MAX  32  Max words per direction per grant. 0 = unlimited.
// - OE_LEAD    1   Cycles oen_o is low before rdn_o goes low. Range 0..3.
// - FLUSH_IDLE 16  Idle cycles after the last TX word before the auto SIWU pulse. 0 = auto flush off.
// PORTS
// - clk_i            in   1          clock
// - rst_i            in   1          reset
// - ftdi_rxf_i       in   1          active low; FTDI has RX data
// - ftdi_txe_i       in   1          active low; FTDI has TX space
// - ftdi_data_in_i   in   DATA_W     FTDI read data
// - ftdi_siwua_o     out  1          active-low send-immediate pulse
// - ftdi_wrn_o       out  1          active-low write strobe
// - ftdi_rdn_o       out  1          active-low read strobe
// - ftdi_oen_o       out  1          active-low output enable
// - ftdi_data_out_o  out  DATA_W     FTDI write data, registered
// - inport_valid_i   in   1          TX stream valid
// - inport_data_i    in   DATA_W     TX stream data
// - inport_accept_o  out  1          TX stream accept
// - outport_valid_o  out  1          RX stream valid
// - outport_data_o   out  DATA_W     RX stream data
// - outport_accept_i in   1          RX stream accept
// - flush_i          in   1          one-cycle request for a SIWU pulse
// - tx_level_o       out  $clog2(TX_DEPTH)+1  TX FIFO occupancy
// - rx_level_o       out  $clog2(RX_DEPTH)+1  RX FIFO occupancy
// BEHAVIOUR
// - Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
// - Reset values: wrn/rdn/oen/siwua = 1; data_out = 0; levels = 0; outport_valid = 0;
//   inport_accept = 1; FSM = IDLE; last_dir = TX; burst_cnt = 0.
// - Reset mid-operation: strobes deassert on that edge. FIFO contents are discarded.
// - Stream ports: valid/accept handshake; transfer on valid&&accept.
//   - Sub-FIFO accept = level != DEPTH; valid = level != 0.
//   - outport_data_o is combinational from the FIFO head.
// - TX holding register (tx_hold_q, hold_valid_q) feeds data_out.
//   - Loads from the TX FIFO when empty, or when the current word completes.
// - Word transfer condition:
//   - RX: !rdn_o && !rxf_i pushes ftdi_data_in_i into the RX FIFO on that edge.
//   - TX: !wrn_o && !txe_i consumes data_out.
// - FSM states (ftdi_sync_pkg::state_t): IDLE, RX_OE, RX, TX, FLUSH.
// - IDLE:
//   - rx_req = !rxf_i && rx_level <= RX_DEPTH-2.
//   - tx_req = !txe_i && (hold_valid_q || tx_level != 0).
//   - Both requesting: the direction not equal to last_dir wins (round-robin). Single request wins.
//   - Winner: RX goes to RX_OE (oen=0) if OE_LEAD > 0, else straight to RX; TX goes to TX (wrn=0).
//   - On grant: burst_cnt = 0 and last_dir = winner.
// - RX_OE: hold OE_LEAD cycles, then RX with rdn = 0.
// - RX exits to IDLE when any of:
//   - rxf_i is high;
//   - rx_level >= RX_DEPTH-1 after this edge's push;
//   - burst_cnt+1 == BURST_MAX on a transfer.
//   - On exit rdn and oen both go to 1 on the same edge. No word is ever dropped.
// - TX exits to IDLE when any of:
//   - txe_i is high;
//   - the completing word was the last (no FIFO data);
//   - the burst limit is reached.
//   - wrn goes to 1 on the exit edge.
// - burst_cnt is a $clog2(BURST_MAX+1)-bit counter. It increments per transferred word and saturates.
// - FLUSH:
//   - Entered from IDLE, at priority below RX/TX requests, when:
//     - flush_pend_q is set; or
//     - idle_cnt == FLUSH_IDLE, with the TX FIFO and holding register empty and >= 1 word sent since the last flush.
//   - siwua_o is driven 0 for exactly 1 cycle, then the FSM returns to IDLE.
//   - Clears flush_pend_q, the sent flag and idle_cnt.
// - flush_i: sets flush_pend_q. The request is held until served, never lost.
// - idle_cnt: clears on any TX transfer and saturates at FLUSH_IDLE.
// - wrn and rdn are never low together. oen is low only in RX_OE/RX.
// STRUCTURE
// - ftdi_sync_pkg: state_t enum, DIR_TX/DIR_RX constants.
// - Sub-module ftdi_sync_fifo #(WIDTH, DEPTH): push/accept, pop/valid, level.
//   - Widths derived with $clog2. Instanced once each for TX and RX.
// - The top holds the FSM, arbitration, burst/idle counters and IOB output registers.
// TESTING
// - Reset with rxf=0, txe=0 -> all strobes 1, outport_valid 0, levels 0.
//   - Assert rst mid-RX -> rdn=oen=1 on the next edge and rx_level=0.
// - RX of 100 words with rxf=0, outport_accept=0, RX_DEPTH=64
//   -> 63 words stored, rx_level stays <= 63, rdn=1. Drain -> the rest arrives in order.
// - Both sides ready, BURST_MAX=4, 20 TX and 20 RX words
//   -> strictly alternating 4-word bursts; wrn and rdn never low together.
// - TX of 10 words with txe toggling every 3 cycles -> FTDI model receives 0..9 exactly once, in order.
// - FLUSH_IDLE=16: send 1 word, then idle -> siwua low for 1 cycle exactly 16 cycles after the transfer.
//   - flush_i during a TX burst -> one pulse after the burst ends.
// - DATA_W=16, OE_LEAD=2 -> oen leads rdn by 2 cycles; 16-bit pattern 0xA5C3.. is passed through intact.

Source files
------------

// File: rtl/ftdi_sync_pkg.sv
// Shared state encoding and direction constants for the FTDI synchronous burst bridge.
package ftdi_sync_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StRxOe  = 3'd1;
    localparam state_t StRx    = 3'd2;
    localparam state_t StTx    = 3'd3;
    localparam state_t StFlush = 3'd4;

    localparam logic DIR_TX = 1'b0;
    localparam logic DIR_RX = 1'b1;

endpackage

// File: rtl/ftdi_sync_fifo.sv
// Single-clock FIFO with valid/accept handshakes and an occupancy count.
module ftdi_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic                     accept_o,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PtrOne = 1;
    localparam logic [AW:0]   LvlOne = 1;
    localparam logic [AW:0]   LvlFull = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign accept_o = (level_q != LvlFull);
    assign valid_o  = (level_q != '0);
    assign level_o  = level_q;
    assign data_o   = mem_q[rd_ptr_q];
    assign do_push  = push_i && accept_o;
    assign do_pop   = pop_i && valid_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LvlOne;
                2'b01:   level_q <= level_q - LvlOne;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/ftdi_sync_burst.sv
// FT245-style synchronous FIFO bridge: TX/RX FIFOs, round-robin burst arbitration,
// programmable OE->RD lead and SIWU send-immediate flushing.
module ftdi_sync_burst #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned TX_DEPTH   = 64,
    parameter int unsigned RX_DEPTH   = 64,
    parameter int unsigned BURST_MAX  = 32,
    parameter int unsigned OE_LEAD    = 1,
    parameter int unsigned FLUSH_IDLE = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        ftdi_rxf_i,
    input  logic                        ftdi_txe_i,
    input  logic [DATA_W-1:0]           ftdi_data_in_i,
    output logic                        ftdi_siwua_o,
    output logic                        ftdi_wrn_o,
    output logic                        ftdi_rdn_o,
    output logic                        ftdi_oen_o,
    output logic [DATA_W-1:0]           ftdi_data_out_o,
    input  logic                        inport_valid_i,
    input  logic [DATA_W-1:0]           inport_data_i,
    output logic                        inport_accept_o,
    output logic                        outport_valid_o,
    output logic [DATA_W-1:0]           outport_data_o,
    input  logic                        outport_accept_i,
    input  logic                        flush_i,
    output logic [$clog2(TX_DEPTH):0]   tx_level_o,
    output logic [$clog2(RX_DEPTH):0]   rx_level_o
);
    import ftdi_sync_pkg::*;

    localparam int unsigned BurstW = (BURST_MAX > 0) ? $clog2(BURST_MAX + 1) : 1;
    localparam int unsigned IdleW  = (FLUSH_IDLE > 0) ? $clog2(FLUSH_IDLE + 1) : 1;

    state_t              state_q, state_d;
    logic                wrn_q, wrn_d, rdn_q, rdn_d, oen_q, oen_d, siwua_q, siwua_d;
    logic [DATA_W-1:0]   tx_hold_q, tx_hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic                last_dir_q, last_dir_d;
    logic [BurstW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [1:0]          oe_cnt_q, oe_cnt_d;
    logic [IdleW-1:0]    idle_cnt_q, idle_cnt_d;
    logic                flush_pend_q, flush_pend_d;
    logic                sent_q, sent_d;

    logic [DATA_W-1:0]   tx_data;
    logic                tx_valid, tx_pop, tx_xfer;
    logic                rx_accept, rx_push, rx_pop;
    logic                rx_req, tx_req, rx_win, flush_go, burst_hit, oe_done, rx_full_nxt;

    ftdi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (inport_valid_i),
        .data_i   (inport_data_i),
        .accept_o (inport_accept_o),
        .pop_i    (tx_pop),
        .data_o   (tx_data),
        .valid_o  (tx_valid),
        .level_o  (tx_level_o)
    );

    ftdi_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (rx_push),
        .data_i   (ftdi_data_in_i),
        .accept_o (rx_accept),
        .pop_i    (rx_pop),
        .data_o   (outport_data_o),
        .valid_o  (outport_valid_o),
        .level_o  (rx_level_o)
    );

    assign rx_push   = !rdn_q && !ftdi_rxf_i && rx_accept;
    assign rx_pop    = outport_valid_o && outport_accept_i;
    assign tx_xfer   = !wrn_q && !ftdi_txe_i;
    // The holding register refills as soon as it empties or its word is taken.
    assign tx_pop    = tx_valid && (!hold_valid_q || tx_xfer);

    assign rx_req    = !ftdi_rxf_i && (32'(rx_level_o) <= RX_DEPTH - 2);
    assign tx_req    = !ftdi_txe_i && (hold_valid_q || tx_valid);
    assign rx_win    = rx_req && (!tx_req || (last_dir_q == DIR_TX));
    assign burst_hit = (BURST_MAX != 0) && ((32'(burst_cnt_q) + 32'd1) == BURST_MAX);
    assign oe_done   = (32'(oe_cnt_q) + 32'd1) >= OE_LEAD;
    assign rx_full_nxt = (32'(rx_level_o) + 32'(rx_push) - 32'(rx_pop)) >= RX_DEPTH - 1;
    assign flush_go  = flush_pend_q ||
                       ((FLUSH_IDLE != 0) && (32'(idle_cnt_q) == FLUSH_IDLE) &&
                        !tx_valid && !hold_valid_q && sent_q);

    always_comb begin
        state_d      = state_q;
        wrn_d        = wrn_q;
        rdn_d        = rdn_q;
        oen_d        = oen_q;
        siwua_d      = 1'b1;
        last_dir_d   = last_dir_q;
        oe_cnt_d     = oe_cnt_q;
        flush_pend_d = flush_pend_q;
        sent_d       = sent_q || tx_xfer;
        tx_hold_d    = tx_hold_q;
        hold_valid_d = hold_valid_q;
        burst_cnt_d  = burst_cnt_q;
        idle_cnt_d   = idle_cnt_q;

        if (tx_xfer) begin
            idle_cnt_d = '0;
        end else if (32'(idle_cnt_q) != FLUSH_IDLE) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
        if ((rx_push || tx_xfer) && (burst_cnt_q != '1)) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
        if (tx_pop) begin
            tx_hold_d    = tx_data;
            hold_valid_d = 1'b1;
        end else if (tx_xfer) begin
            hold_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (rx_win) begin
                    last_dir_d  = DIR_RX;
                    burst_cnt_d = '0;
                    oe_cnt_d    = '0;
                    oen_d       = 1'b0;
                    if (OE_LEAD == 0) begin
                        state_d = StRx;
                        rdn_d   = 1'b0;
                    end else begin
                        state_d = StRxOe;
                    end
                end else if (tx_req) begin
                    last_dir_d  = DIR_TX;
                    burst_cnt_d = '0;
                    wrn_d       = 1'b0;
                    state_d     = StTx;
                end else if (flush_go) begin
                    siwua_d = 1'b0;
                    state_d = StFlush;
                end
            end
            StRxOe: begin
                if (oe_done) begin
                    rdn_d   = 1'b0;
                    state_d = StRx;
                end else begin
                    oe_cnt_d = oe_cnt_q + 1'b1;
                end
            end
            StRx: begin
                if (ftdi_rxf_i || rx_full_nxt || (rx_push && burst_hit)) begin
                    rdn_d   = 1'b1;
                    oen_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StTx: begin
                if (ftdi_txe_i || (tx_xfer && (!tx_valid || burst_hit))) begin
                    wrn_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StFlush: begin
                flush_pend_d = 1'b0;
                sent_d       = 1'b0;
                idle_cnt_d   = '0;
                state_d      = StIdle;
            end
            default: begin
                wrn_d   = 1'b1;
                rdn_d   = 1'b1;
                oen_d   = 1'b1;
                state_d = StIdle;
            end
        endcase

        // A request arriving while a pulse is being served is kept for another pulse.
        if (flush_i) flush_pend_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            wrn_q        <= 1'b1;
            rdn_q        <= 1'b1;
            oen_q        <= 1'b1;
            siwua_q      <= 1'b1;
            tx_hold_q    <= '0;
            hold_valid_q <= 1'b0;
            last_dir_q   <= DIR_TX;
            burst_cnt_q  <= '0;
            oe_cnt_q     <= '0;
            idle_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            sent_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wrn_q        <= wrn_d;
            rdn_q        <= rdn_d;
            oen_q        <= oen_d;
            siwua_q      <= siwua_d;
            tx_hold_q    <= tx_hold_d;
            hold_valid_q <= hold_valid_d;
            last_dir_q   <= last_dir_d;
            burst_cnt_q  <= burst_cnt_d;
            oe_cnt_q     <= oe_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            flush_pend_q <= flush_pend_d;
            sent_q       <= sent_d;
        end
    end

    assign ftdi_wrn_o      = wrn_q;
    assign ftdi_rdn_o      = rdn_q;
    assign ftdi_oen_o      = oen_q;
    assign ftdi_siwua_o    = siwua_q;
    assign ftdi_data_out_o = tx_hold_q;

endmodule

// File: tb/tb_ftdi_sync_burst.sv
// Directed bench: instance A uses the default 8-bit configuration, instance B is 16-bit
// with BURST_MAX=4 and OE_LEAD=2. Both share clock and reset.
module tb_ftdi_sync_burst;
    localparam int FlushIdle = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_rxf = 1'b1, a_txe = 1'b1, a_inv = 1'b0, a_outacc = 1'b0, a_flush = 1'b0;
    logic [7:0]  a_din = '0, a_ind = '0;
    logic        a_siwua, a_wrn, a_rdn, a_oen, a_inacc, a_outv;
    logic [7:0]  a_dout, a_outd;
    logic [6:0]  a_txl, a_rxl;

    logic        b_rxf = 1'b1, b_txe = 1'b1, b_inv = 1'b0, b_outacc = 1'b0, b_flush = 1'b0;
    logic [15:0] b_din = '0, b_ind = '0;
    logic        b_siwua, b_wrn, b_rdn, b_oen, b_inacc, b_outv;
    logic [15:0] b_dout, b_outd;
    logic [6:0]  b_txl, b_rxl;

    ftdi_sync_burst u_dut_a (
        .clk_i(clk), .rst_i(rst), .ftdi_rxf_i(a_rxf), .ftdi_txe_i(a_txe),
        .ftdi_data_in_i(a_din), .ftdi_siwua_o(a_siwua), .ftdi_wrn_o(a_wrn),
        .ftdi_rdn_o(a_rdn), .ftdi_oen_o(a_oen), .ftdi_data_out_o(a_dout),
        .inport_valid_i(a_inv), .inport_data_i(a_ind), .inport_accept_o(a_inacc),
        .outport_valid_o(a_outv), .outport_data_o(a_outd), .outport_accept_i(a_outacc),
        .flush_i(a_flush), .tx_level_o(a_txl), .rx_level_o(a_rxl)
    );

    ftdi_sync_burst #(.DATA_W(16), .BURST_MAX(4), .OE_LEAD(2)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .ftdi_rxf_i(b_rxf), .ftdi_txe_i(b_txe),
        .ftdi_data_in_i(b_din), .ftdi_siwua_o(b_siwua), .ftdi_wrn_o(b_wrn),
        .ftdi_rdn_o(b_rdn), .ftdi_oen_o(b_oen), .ftdi_data_out_o(b_dout),
        .inport_valid_i(b_inv), .inport_data_i(b_ind), .inport_accept_o(b_inacc),
        .outport_valid_o(b_outv), .outport_data_o(b_outd), .outport_accept_i(b_outacc),
        .flush_i(b_flush), .tx_level_o(b_txl), .rx_level_o(b_rxl)
    );

    int vecs = 0, errs = 0, cyc = 0;
    // Source models: index of next word and number of words offered.
    int a_rx_i = 0, a_rx_n = 0, a_in_i = 0, a_in_n = 0;
    int b_rx_i = 0, b_rx_n = 0, b_in_i = 0, b_in_n = 0;
    // Sinks and monitors.
    logic [15:0] a_txg [256], a_rxg [256], b_txg [256], b_rxg [256];
    int a_txn = 0, a_outn = 0, b_txn = 0, b_outn = 0;
    int a_last_tx = -1, a_sw_n = 0, a_sw_cyc = -1, a_rxl_max = 0;
    int a_ovl = 0, b_ovl = 0;
    int b_run_n = 0;
    logic b_run_dir [32];
    int b_run_len [32];
    logic b_oen_prev = 1'b1, b_rdn_prev = 1'b1;
    int b_oen_fall = -1, b_rdn_fall = -1;

    task automatic tick();
        logic arx, atx, aout, ain, brx, btx, bout, bin;
        @(negedge clk);
        arx  = !a_rdn && !a_rxf;
        atx  = !a_wrn && !a_txe;
        aout = a_outv && a_outacc;
        ain  = a_inv && a_inacc;
        brx  = !b_rdn && !b_rxf;
        btx  = !b_wrn && !b_txe;
        bout = b_outv && b_outacc;
        bin  = b_inv && b_inacc;
        if (!a_wrn && !a_rdn) a_ovl++;
        if (!b_wrn && !b_rdn) b_ovl++;
        if (int'(a_rxl) > a_rxl_max) a_rxl_max = int'(a_rxl);
        if (atx) begin
            if (a_txn < 256) a_txg[a_txn] = {8'h00, a_dout};
            a_txn++;
            a_last_tx = cyc + 1;
        end
        if (aout) begin
            if (a_outn < 256) a_rxg[a_outn] = {8'h00, a_outd};
            a_outn++;
        end
        if (!a_siwua) begin
            a_sw_n++;
            a_sw_cyc = cyc;
        end
        if (btx) begin
            if (b_txn < 256) b_txg[b_txn] = b_dout;
            b_txn++;
        end
        if (bout) begin
            if (b_outn < 256) b_rxg[b_outn] = b_outd;
            b_outn++;
        end
        if (brx || btx) begin
            if (b_run_n > 0 && b_run_dir[b_run_n-1] == brx) begin
                b_run_len[b_run_n-1]++;
            end else if (b_run_n < 32) begin
                b_run_dir[b_run_n] = brx;
                b_run_len[b_run_n] = 1;
                b_run_n++;
            end
        end
        if (b_oen_prev && !b_oen && b_oen_fall < 0) b_oen_fall = cyc;
        if (b_rdn_prev && !b_rdn && b_rdn_fall < 0) b_rdn_fall = cyc;
        b_oen_prev = b_oen;
        b_rdn_prev = b_rdn;
        @(posedge clk);
        cyc++;
        #1;
        if (arx) a_rx_i++;
        if (ain) a_in_i++;
        if (brx) b_rx_i++;
        if (bin) b_in_i++;
        a_rxf = (a_rx_i >= a_rx_n);
        a_din = 8'(a_rx_i);
        a_inv = (a_in_i < a_in_n);
        a_ind = 8'(a_in_i);
        b_rxf = (b_rx_i >= b_rx_n);
        b_din = 16'hA5C3 + 16'(b_rx_i);
        b_inv = (b_in_i < b_in_n);
        b_ind = 16'h5A3C + 16'(b_in_i);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_rx_n = 1000;
        a_rxf = 1'b0;
        a_txe = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        a_rxf = 1'b0;
        a_txe = 1'b0;
        #1;
        vecs++;
        if ({a_wrn, a_rdn, a_oen, a_siwua} !== 4'b1111) begin
            errs++;
            $display("FAIL reset_strobes got %b want 1111", {a_wrn, a_rdn, a_oen, a_siwua});
        end
        vecs++;
        if (a_outv !== 1'b0) begin
            errs++;
            $display("FAIL reset_outvalid got %b want 0", a_outv);
        end
        vecs++;
        if (a_rxl !== 7'd0 || a_txl !== 7'd0) begin
            errs++;
            $display("FAIL reset_levels got rx=%0d tx=%0d want 0/0", a_rxl, a_txl);
        end
        vecs++;
        if (a_dout !== 8'h00) begin
            errs++;
            $display("FAIL reset_dataout got %h want 00", a_dout);
        end
        vecs++;
        if (a_inacc !== 1'b1) begin
            errs++;
            $display("FAIL reset_accept got %b want 1", a_inacc);
        end
        a_rx_n = a_rx_i;
        a_rxf = 1'b1;
        a_txe = 1'b1;
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_rx_fill_drain();
        int bad;
        a_rx_i = 0;
        a_rx_n = 100;
        a_rxf = 1'b0;
        a_din = 8'd0;
        a_outacc = 1'b0;
        a_outn = 0;
        a_rxl_max = 0;
        for (int i = 0; i < 300; i++) tick();
        vecs++;
        if (a_rxl !== 7'd63) begin
            errs++;
            $display("FAIL rx_fill_level got %0d want 63", a_rxl);
        end
        vecs++;
        if (a_rx_i !== 63) begin
            errs++;
            $display("FAIL rx_fill_taken got %0d want 63", a_rx_i);
        end
        vecs++;
        if (a_rxl_max > 63) begin
            errs++;
            $display("FAIL rx_fill_max got %0d want <=63", a_rxl_max);
        end
        vecs++;
        if ({a_rdn, a_oen} !== 2'b11) begin
            errs++;
            $display("FAIL rx_fill_strobes got %b want 11", {a_rdn, a_oen});
        end
        a_outacc = 1'b1;
        for (int i = 0; i < 600 && a_outn < 100; i++) tick();
        bad = 0;
        for (int i = 0; i < 100; i++) if (a_rxg[i] !== 16'(i)) bad++;
        vecs++;
        if (a_outn !== 100 || bad != 0) begin
            errs++;
            $display("FAIL rx_drain got %0d words %0d bad want 100 words 0 bad", a_outn, bad);
        end
        a_outacc = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_rx();
        logic seen;
        seen = 1'b0;
        a_rx_n = a_rx_i + 50;
        a_rxf = 1'b0;
        a_din = 8'(a_rx_i);
        a_outacc = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = !a_rdn;
        end
        vecs++;
        if (!seen) begin
            errs++;
            $display("FAIL rst_mid_rx_start got rdn=%b want 0 within 10 cycles", a_rdn);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        vecs++;
        if ({a_rdn, a_oen} !== 2'b11) begin
            errs++;
            $display("FAIL rst_mid_rx_strobes got %b want 11", {a_rdn, a_oen});
        end
        vecs++;
        if (a_rxl !== 7'd0 || a_outv !== 1'b0) begin
            errs++;
            $display("FAIL rst_mid_rx_level got %0d valid %b want 0/0", a_rxl, a_outv);
        end
        rst = 1'b0;
        a_rx_n = a_rx_i;
        a_rxf = 1'b1;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_tx_toggle();
        int bad;
        pulse_reset();
        a_in_i = 0;
        a_in_n = 10;
        a_inv = 1'b1;
        a_ind = 8'd0;
        a_txe = 1'b1;
        a_txn = 0;
        for (int i = 0; i < 15; i++) tick();
        vecs++;
        if (a_txl !== 7'd9) begin
            errs++;
            $display("FAIL tx_preload_level got %0d want 9", a_txl);
        end
        for (int k = 0; k < 150; k++) begin
            a_txe = ((k / 3) % 2) != 0;
            tick();
        end
        a_txe = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) if (a_txg[i] !== 16'(i)) bad++;
        vecs++;
        if (a_txn !== 10 || bad != 0) begin
            errs++;
            $display("FAIL tx_toggle got %0d words %0d bad want 10 words 0 bad", a_txn, bad);
        end
    endtask

    task automatic test_flush_idle();
        pulse_reset();
        a_in_i = 0;
        a_in_n = 1;
        a_inv = 1'b1;
        a_ind = 8'd0;
        a_txe = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        a_txn = 0;
        a_sw_n = 0;
        a_sw_cyc = -1;
        a_txe = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        a_txe = 1'b1;
        vecs++;
        if (a_txn !== 1) begin
            errs++;
            $display("FAIL flush_idle_words got %0d want 1", a_txn);
        end
        vecs++;
        if (a_sw_n !== 1) begin
            errs++;
            $display("FAIL flush_idle_width got %0d low cycles want 1", a_sw_n);
        end
        // The pulse launches on the edge that sees FlushIdle counted idle cycles.
        vecs++;
        if (a_sw_cyc !== a_last_tx + FlushIdle + 1) begin
            errs++;
            $display("FAIL flush_idle_time got edge %0d want %0d", a_sw_cyc,
                     a_last_tx + FlushIdle + 1);
        end
    endtask

    task automatic test_flush_req();
        logic sent_req;
        sent_req = 1'b0;
        pulse_reset();
        a_in_i = 0;
        a_in_n = 10;
        a_inv = 1'b1;
        a_ind = 8'd0;
        a_txe = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        a_txn = 0;
        a_sw_n = 0;
        a_sw_cyc = -1;
        a_txe = 1'b0;
        for (int k = 0; k < 60; k++) begin
            a_flush = (a_txn == 2) && !sent_req;
            if (a_flush) sent_req = 1'b1;
            tick();
        end
        a_flush = 1'b0;
        a_txe = 1'b1;
        vecs++;
        if (a_txn !== 10) begin
            errs++;
            $display("FAIL flush_req_words got %0d want 10", a_txn);
        end
        vecs++;
        if (a_sw_n !== 1) begin
            errs++;
            $display("FAIL flush_req_count got %0d low cycles want 1", a_sw_n);
        end
        vecs++;
        if (a_sw_cyc !== a_last_tx + 1) begin
            errs++;
            $display("FAIL flush_req_time got edge %0d want %0d", a_sw_cyc, a_last_tx + 1);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        pulse_reset();
        b_in_i = 0;
        b_in_n = 20;
        b_inv = 1'b1;
        b_ind = 16'h5A3C;
        b_txe = 1'b1;
        b_rx_i = 0;
        b_rx_n = 0;
        b_rxf = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        b_txn = 0;
        b_outn = 0;
        b_run_n = 0;
        b_oen_fall = -1;
        b_rdn_fall = -1;
        b_outacc = 1'b1;
        b_rx_n = 20;
        b_din = 16'hA5C3;
        b_rxf = 1'b0;
        b_txe = 1'b0;
        for (int i = 0; i < 300; i++) tick();
        b_txe = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (b_run_dir[i] !== (i % 2 == 0) || b_run_len[i] !== 4) bad++;
        end
        vecs++;
        if (b_run_n !== 10 || bad != 0) begin
            errs++;
            $display("FAIL burst_pattern got %0d runs %0d bad want 10 runs 0 bad", b_run_n, bad);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) if (b_rxg[i] !== 16'hA5C3 + 16'(i)) bad++;
        vecs++;
        if (b_outn !== 20 || bad != 0) begin
            errs++;
            $display("FAIL rx16_data got %0d words %0d bad want 20 words 0 bad", b_outn, bad);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) if (b_txg[i] !== 16'h5A3C + 16'(i)) bad++;
        vecs++;
        if (b_txn !== 20 || bad != 0) begin
            errs++;
            $display("FAIL tx16_data got %0d words %0d bad want 20 words 0 bad", b_txn, bad);
        end
        vecs++;
        if (b_oen_fall < 0 || b_rdn_fall - b_oen_fall !== 2) begin
            errs++;
            $display("FAIL oe_lead got oen@%0d rdn@%0d want gap 2", b_oen_fall, b_rdn_fall);
        end
    endtask

    task automatic test_no_overlap();
        vecs++;
        if (a_ovl !== 0 || b_ovl !== 0) begin
            errs++;
            $display("FAIL wr_rd_overlap got a=%0d b=%0d cycles want 0/0", a_ovl, b_ovl);
        end
    endtask

    initial begin
        test_reset();
        test_rx_fill_drain();
        test_reset_mid_rx();
        test_tx_toggle();
        test_flush_idle();
        test_flush_req();
        test_back_to_back();
        test_no_overlap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
